// File: rtl/instr_encoder_loader_if.sv
// Instruction-request handshake between a program source and the encoder/loader.
interface instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes mnemonic-level requests into MIPS words and loads them sequentially
// into instruction memory, releasing the core once the program is complete.
module instr_encoder_loader #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    finish,
  instr_encoder_loader_if.slave   req,
  output logic                    im_we,
  output logic [ADDR_WIDTH-1:0]   im_addr,
  output logic [31:0]             im_wdata,
  output logic [ADDR_WIDTH:0]     count,
  output logic                    full,
  output logic                    err_illegal,
  output logic                    cpu_run
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t      state, state_next;
  logic        accept;
  logic        last_slot;
  logic        restart;
  logic        illegal;
  logic [31:0] word;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return {6'h00, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  // count never exceeds DEPTH, so its top bit alone marks a full memory
  assign full      = count[ADDR_WIDTH];
  assign last_slot = (&count[ADDR_WIDTH-1:0]) && !count[ADDR_WIDTH];

  assign req.in_ready = (state == LOAD) && !full;
  assign accept       = req.in_valid && req.in_ready;
  assign restart      = (state != LOAD) && start;

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (req.in_op)
      5'd0:  word = r_word(req.in_rs, req.in_rt, req.in_rd, 5'd0, 6'h20);
      5'd1:  word = r_word(req.in_rs, req.in_rt, req.in_rd, 5'd0, 6'h22);
      5'd2:  word = r_word(req.in_rs, req.in_rt, req.in_rd, 5'd0, 6'h21);
      5'd3:  word = r_word(req.in_rs, req.in_rt, req.in_rd, 5'd0, 6'h23);
      5'd4:  word = r_word(req.in_rs, req.in_rt, req.in_rd, 5'd0, 6'h2A);
      5'd5:  word = r_word(5'd0, req.in_rt, req.in_rd, req.in_shamt, 6'h00);
      5'd6:  word = r_word(5'd0, req.in_rt, req.in_rd, req.in_shamt, 6'h02);
      5'd7:  word = r_word(5'd0, req.in_rt, req.in_rd, req.in_shamt, 6'h03);
      5'd8:  word = i_word(6'h0D, req.in_rs, req.in_rt, req.in_imm);
      5'd9:  word = i_word(6'h04, req.in_rs, req.in_rt, req.in_imm);
      5'd10: word = i_word(6'h05, req.in_rs, req.in_rt, req.in_imm);
      5'd11: word = i_word(6'h23, req.in_rs, req.in_rt, req.in_imm);
      5'd12: word = i_word(6'h2B, req.in_rs, req.in_rt, req.in_imm);
      5'd13: word = i_word(6'h0F, 5'd0, req.in_rt, req.in_imm);
      5'd14: word = {6'h02, req.in_target};
      5'd15: word = i_word(6'h0A, req.in_rs, req.in_rt, req.in_imm);
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (finish || (accept && last_slot)) state_next = DONE;
      DONE:    if (start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      im_we       <= 1'b0;
      im_addr     <= '0;
      im_wdata    <= '0;
      count       <= '0;
      err_illegal <= 1'b0;
      cpu_run     <= 1'b0;
    end else begin
      state <= state_next;
      im_we <= accept;
      if (accept) begin
        im_addr  <= count[ADDR_WIDTH-1:0];
        im_wdata <= word;
        count    <= count + (ADDR_WIDTH+1)'(1);
        if (illegal) err_illegal <= 1'b1;
      end
      if (restart) begin
        count       <= '0;
        err_illegal <= 1'b0;
      end
      // Look ahead one cycle so run asserts exactly in the first DONE cycle without a write
      cpu_run <= (state_next == DONE) && !accept;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed and randomized checks of instr_encoder_loader against a table-driven encoding model.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  logic rst, start, finish, start_s, finish_s;

  instr_encoder_loader_if bus();
  instr_encoder_loader_if bus_s();

  logic        im_we, full, err_illegal, cpu_run;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic [10:0] count;

  logic        s_we, s_full, s_err, s_run;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_count;

  int checks = 0;
  int failures = 0;

  instr_encoder_loader dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .req(bus.slave),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .count(count),
    .full(full), .err_illegal(err_illegal), .cpu_run(cpu_run)
  );

  instr_encoder_loader #(.ADDR_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .finish(finish_s), .req(bus_s.slave),
    .im_we(s_we), .im_addr(s_addr), .im_wdata(s_wdata), .count(s_count),
    .full(s_full), .err_illegal(s_err), .cpu_run(s_run)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  // Mnemonic table: major opcode for I/J forms, funct for R forms.
  function automatic logic [31:0] ref_encode(input int op, input int rs, input int rt,
                                             input int rd, input int sh, input int imm,
                                             input int tgt);
    int code[16] = '{32'h20, 32'h22, 32'h21, 32'h23, 32'h2A, 32'h00, 32'h02, 32'h03,
                     32'h0D, 32'h04, 32'h05, 32'h23, 32'h2B, 32'h0F, 32'h02, 32'h0A};
    longint w;
    if (op >= 16) return 32'h0;
    if (op <= 4)       w = rs * 2**21 + rt * 2**16 + rd * 2**11 + code[op];
    else if (op <= 7)  w = rt * 2**16 + rd * 2**11 + sh * 2**6 + code[op];
    else if (op == 14) w = longint'(code[op]) * 2**26 + tgt;
    else if (op == 13) w = longint'(code[op]) * 2**26 + rt * 2**16 + imm;
    else               w = longint'(code[op]) * 2**26 + rs * 2**21 + rt * 2**16 + imm;
    return 32'(w);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int op, input int rs, input int rt, input int rd,
                      input int sh, input int imm, input int tgt);
    bus.in_valid  = 1'b1;
    bus.in_op     = 5'(op);
    bus.in_rs     = 5'(rs);
    bus.in_rt     = 5'(rt);
    bus.in_rd     = 5'(rd);
    bus.in_shamt  = 5'(sh);
    bus.in_imm    = 16'(imm);
    bus.in_target = 26'(tgt);
  endtask

  task automatic check_write(input string tag, input int addr, input logic [31:0] data);
    chk({tag, "_we"}, 64'(im_we), 64'(1));
    chk({tag, "_addr"}, 64'(im_addr), 64'(addr));
    chk({tag, "_data"}, 64'(im_wdata), 64'(data));
  endtask

  initial begin
    int mcount;
    logic merr;
    int op, rs, rt, rd, sh, imm, tgt;
    logic v;

    rst = 1'b1; start = 1'b0; finish = 1'b0; start_s = 1'b0; finish_s = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
    bus.in_shamt = '0; bus.in_imm = '0; bus.in_target = '0;
    bus_s.in_valid = 1'b0; bus_s.in_op = '0; bus_s.in_rs = '0; bus_s.in_rt = '0;
    bus_s.in_rd = '0; bus_s.in_shamt = '0; bus_s.in_imm = '0; bus_s.in_target = '0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_we", 64'(im_we), 64'(0));
    chk("rst_addr", 64'(im_addr), 64'(0));
    chk("rst_wdata", 64'(im_wdata), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_err", 64'(err_illegal), 64'(0));
    chk("rst_run", 64'(cpu_run), 64'(0));
    chk("rst_ready", 64'(bus.in_ready), 64'(0));

    // R-type and shift encodings
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_ready", 64'(bus.in_ready), 64'(1));
    beat(0, 1, 2, 3, 9, 0, 0); tick();
    check_write("t1_add", 0, 32'h00221820);
    chk("t1_count1", 64'(count), 64'(1));
    beat(5, 7, 3, 2, 4, 0, 0); tick();
    check_write("t1_sll", 1, 32'h00031100);
    chk("t1_count2", 64'(count), 64'(2));
    bus.in_valid = 1'b0; tick();
    chk("t1_idle_we", 64'(im_we), 64'(0));

    // Plain finish then restart
    finish = 1'b1; tick(); finish = 1'b0;
    chk("fin_run", 64'(cpu_run), 64'(1));
    chk("fin_ready", 64'(bus.in_ready), 64'(0));
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_run", 64'(cpu_run), 64'(0));
    chk("restart_count", 64'(count), 64'(0));

    // I-type and J encodings
    beat(11, 5, 4, 0, 0, 8, 0); tick();
    check_write("t2_lw", 0, 32'h8CA40008);
    beat(9, 1, 2, 0, 0, 16'hFFFF, 0); tick();
    check_write("t2_beq", 1, 32'h1022FFFF);
    beat(13, 9, 1, 0, 0, 16'h1234, 0); tick();
    check_write("t2_lui", 2, 32'h3C011234);
    beat(14, 3, 3, 3, 3, 3, 26'h10); tick();
    check_write("t2_j", 3, 32'h08000010);

    // finish coincident with an accepted beat
    beat(8, 0, 1, 0, 0, 5, 0); finish = 1'b1; tick();
    bus.in_valid = 1'b0; finish = 1'b0;
    check_write("t3_ori", 4, 32'h34010005);
    chk("t3_run0", 64'(cpu_run), 64'(0));
    chk("t3_ready0", 64'(bus.in_ready), 64'(0));
    tick();
    chk("t3_run1", 64'(cpu_run), 64'(1));
    chk("t3_we", 64'(im_we), 64'(0));
    chk("t3_ready1", 64'(bus.in_ready), 64'(0));
    bus.in_valid = 1'b1; finish = 1'b1; tick(); bus.in_valid = 1'b0; finish = 1'b0;
    chk("t3_done_nowrite", 64'(im_we), 64'(0));
    chk("t3_done_count", 64'(count), 64'(5));

    // Illegal op
    start = 1'b1; tick(); start = 1'b0;
    chk("t4_count0", 64'(count), 64'(0));
    beat(20, 31, 31, 31, 31, 16'hFFFF, 26'h3FFFFFF); tick();
    check_write("t4_ill", 0, 32'h0);
    chk("t4_count1", 64'(count), 64'(1));
    chk("t4_err", 64'(err_illegal), 64'(1));
    beat(2, 4, 5, 6, 0, 0, 0); tick();
    check_write("t4_addu", 1, 32'h00853021);
    chk("t4_err_sticky", 64'(err_illegal), 64'(1));
    bus.in_valid = 1'b0; finish = 1'b1; tick(); finish = 1'b0;
    chk("t4_err_done", 64'(err_illegal), 64'(1));
    start = 1'b1; tick(); start = 1'b0;
    chk("t4_err_clr", 64'(err_illegal), 64'(0));
    chk("t4_count_clr", 64'(count), 64'(0));

    // Randomized stream against the reference model
    mcount = 0; merr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      v = 1'($urandom_range(0, 1));
      op = int'($urandom_range(0, 31)); rs = int'($urandom_range(0, 31));
      rt = int'($urandom_range(0, 31)); rd = int'($urandom_range(0, 31));
      sh = int'($urandom_range(0, 31)); imm = int'($urandom_range(0, 65535));
      tgt = int'($urandom & 32'h03FF_FFFF);
      beat(op, rs, rt, rd, sh, imm, tgt);
      bus.in_valid = v;
      chk("rnd_ready", 64'(bus.in_ready), 64'(1));
      tick();
      chk("rnd_we", 64'(im_we), 64'(v));
      if (v) begin
        chk("rnd_addr", 64'(im_addr), 64'(mcount));
        chk("rnd_data", 64'(im_wdata), 64'(ref_encode(op, rs, rt, rd, sh, imm, tgt)));
        mcount++;
        if (op >= 16) merr = 1'b1;
      end
      chk("rnd_count", 64'(count), 64'(mcount));
      chk("rnd_err", 64'(err_illegal), 64'(merr));
    end
    bus.in_valid = 1'b0; finish = 1'b1; tick(); finish = 1'b0;
    chk("rnd_fin_run", 64'(cpu_run), 64'(1));

    // Full boundary on the 4-word instance
    start_s = 1'b1; tick(); start_s = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_s.in_valid = 1'b1; bus_s.in_op = 5'(i); bus_s.in_rs = 5'(i + 1);
      bus_s.in_rt = 5'(i + 2); bus_s.in_rd = 5'(i + 3); bus_s.in_shamt = 5'(i);
      chk("t5_ready_pre", 64'(bus_s.in_ready), 64'(i < 4));
      tick();
      chk("t5_we", 64'(s_we), 64'(i < 4));
      if (i < 4) begin
        chk("t5_addr", 64'(s_addr), 64'(i));
        chk("t5_data", 64'(s_wdata), 64'(ref_encode(i, i + 1, i + 2, i + 3, i, 0, 0)));
      end
      chk("t5_count", 64'((i < 4) ? i + 1 : 4), 64'(s_count));
      chk("t5_full", 64'(s_full), 64'(i >= 3));
      chk("t5_run", 64'(s_run), 64'(i == 4));
    end
    bus_s.in_valid = 1'b0;

    // Reset mid-operation
    start = 1'b1; tick(); start = 1'b0;
    beat(1, 1, 1, 1, 0, 0, 0); tick();
    chk("t6_accepted", 64'(im_we), 64'(1));
    bus.in_valid = 1'b1; rst = 1'b1; tick(); rst = 1'b0; bus.in_valid = 1'b0;
    chk("t6_we", 64'(im_we), 64'(0));
    chk("t6_addr", 64'(im_addr), 64'(0));
    chk("t6_wdata", 64'(im_wdata), 64'(0));
    chk("t6_count", 64'(count), 64'(0));
    chk("t6_full", 64'(full), 64'(0));
    chk("t6_err", 64'(err_illegal), 64'(0));
    chk("t6_run", 64'(cpu_run), 64'(0));
    chk("t6_ready", 64'(bus.in_ready), 64'(0));
    finish = 1'b1; bus.in_valid = 1'b1; tick(); finish = 1'b0; bus.in_valid = 1'b0;
    chk("t6_idle_run", 64'(cpu_run), 64'(0));
    chk("t6_idle_we", 64'(im_we), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
